// File: rtl/instr_issuer_pkg.sv
// Shared definitions for the instruction issuer: sequencer states, the
// default halt opcode and the field layout of a 16-bit instruction word.
package instr_issuer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_HALTED = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    localparam logic [3:0] HALT_OP_DEFAULT = 4'b1111;

    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int P1_HI = 11;
    localparam int P1_LO = 6;
    localparam int P2_HI = 5;
    localparam int P2_LO = 0;

    function automatic logic [3:0] instr_opcode(input logic [15:0] w);
        return w[OP_HI:OP_LO];
    endfunction

    function automatic logic [5:0] instr_p1(input logic [15:0] w);
        return w[P1_HI:P1_LO];
    endfunction

    function automatic logic [5:0] instr_p2(input logic [15:0] w);
        return w[P2_HI:P2_LO];
    endfunction

endpackage

// File: rtl/instr_issuer_mem.sv
// 16x16 instruction storage: one synchronous write port, one combinational
// read port. Contents are deliberately not reset so a program survives reset.
module instr_mem (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [3:0]  waddr_i,
    input  logic [15:0] wdata_i,
    input  logic [3:0]  raddr_i,
    output logic [15:0] rdata_o
);

    logic [15:0] mem_q [16];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_issuer.sv
// Instruction issuer: fetches instructions from a small program memory,
// hands each to the control FSM with a START pulse and tracks the PC.
module instr_issuer
    import instr_issuer_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 64,
    parameter logic [3:0] HALT_OP        = HALT_OP_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        RUN,
    input  logic        LOAD_EN,
    input  logic [3:0]  LOAD_ADDR,
    input  logic [15:0] LOAD_DATA,
    input  logic        PCinc,
    input  logic        finish,
    output logic        START,
    output logic [3:0]  OPCODE,
    output logic [5:0]  p1,
    output logic [5:0]  p2,
    output logic [3:0]  PC,
    output logic        BUSY,
    output logic        DONE,
    output logic        TIMEOUT
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t          state_q, state_d;
    logic [3:0]      pc_q, pc_d;
    logic [3:0]      op_q, op_d;
    logic [5:0]      p1_q, p1_d;
    logic [5:0]      p2_q, p2_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            inc_seen_q, inc_seen_d;
    logic            busy;
    logic            mem_we;
    logic [15:0]     mem_rdata;

    assign busy   = (state_q == S_FETCH) || (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign mem_we = LOAD_EN && !busy;

    instr_mem u_mem (
        .clk_i   (CLK),
        .we_i    (mem_we),
        .waddr_i (LOAD_ADDR),
        .wdata_i (LOAD_DATA),
        .raddr_i (pc_q),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            pc_q       <= 4'd0;
            op_q       <= 4'd0;
            p1_q       <= 6'd0;
            p2_q       <= 6'd0;
            tmo_q      <= '0;
            inc_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            op_q       <= op_d;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            tmo_q      <= tmo_d;
            inc_seen_q <= inc_seen_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        op_d       = op_q;
        p1_d       = p1_q;
        p2_d       = p2_q;
        tmo_d      = tmo_q;
        inc_seen_d = inc_seen_q;

        case (state_q)
            S_IDLE: begin
                // A load in the same cycle as RUN takes priority; start waits.
                if (RUN && !LOAD_EN) begin
                    pc_d    = 4'd0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                op_d    = instr_opcode(mem_rdata);
                p1_d    = instr_p1(mem_rdata);
                p2_d    = instr_p2(mem_rdata);
                state_d = (instr_opcode(mem_rdata) == HALT_OP) ? S_HALTED : S_ISSUE;
            end
            S_ISSUE: begin
                tmo_d      = '0;
                inc_seen_d = 1'b0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                tmo_d = tmo_q + 1'b1;
                if (PCinc) begin
                    pc_d       = pc_q + 4'd1;
                    inc_seen_d = 1'b1;
                end
                // An instruction that never pulsed PCinc still advances by one.
                if (finish) begin
                    state_d = S_FETCH;
                    if (!PCinc && !inc_seen_q) begin
                        pc_d = pc_q + 4'd1;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_ERROR;
                end
            end
            S_HALTED: begin
                if (!RUN) begin
                    state_d = S_IDLE;
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign START   = (state_q == S_ISSUE);
    assign OPCODE  = op_q;
    assign p1      = p1_q;
    assign p2      = p2_q;
    assign PC      = pc_q;
    assign BUSY    = busy;
    assign DONE    = (state_q == S_HALTED);
    assign TIMEOUT = (state_q == S_ERROR);

endmodule

// File: tb/tb_instr_issuer.sv
// Scoreboard bench for instr_issuer: the bench plays the control FSM, a
// program-level model predicts each issued instruction and the PC.
module tb_instr_issuer;

    localparam int         TO   = 64;
    localparam logic [3:0] HALT = 4'hF;

    logic        CLK, RESET, RUN, LOAD_EN, PCinc, finish;
    logic [3:0]  LOAD_ADDR;
    logic [15:0] LOAD_DATA;
    logic        START, BUSY, DONE, TIMEOUT;
    logic [3:0]  OPCODE, PC;
    logic [5:0]  p1, p2;

    instr_issuer #(.TIMEOUT_CYCLES(TO), .HALT_OP(HALT)) dut (
        .CLK(CLK), .RESET(RESET), .RUN(RUN), .LOAD_EN(LOAD_EN),
        .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA), .PCinc(PCinc),
        .finish(finish), .START(START), .OPCODE(OPCODE), .p1(p1), .p2(p2),
        .PC(PC), .BUSY(BUSY), .DONE(DONE), .TIMEOUT(TIMEOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] op;
        logic [5:0] p1;
        logic [5:0] p2;
        logic [3:0] pc;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] mem_m [16];
    int          pc_m = 0;
    exp_t        sb [$];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every START must match the oldest predicted instruction.
    exp_t mon_e;
    always @(negedge CLK) begin
        if (START === 1'b1) begin
            if (sb.size() == 0) begin
                chk("start_without_expectation", sb.size(), 1);
            end else begin
                mon_e = sb.pop_front();
                chk("start_opcode", int'(OPCODE), int'(mon_e.op));
                chk("start_p1", int'(p1), int'(mon_e.p1));
                chk("start_p2", int'(p2), int'(mon_e.p2));
                chk("start_pc", int'(PC), int'(mon_e.pc));
                chk("start_busy", int'(BUSY), 1);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_outputs_check();
        chk("rst_start", int'(START), 0);
        chk("rst_opcode", int'(OPCODE), 0);
        chk("rst_p1", int'(p1), 0);
        chk("rst_p2", int'(p2), 0);
        chk("rst_pc", int'(PC), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_timeout", int'(TIMEOUT), 0);
    endtask

    task automatic load(input int a, input logic [15:0] d);
        LOAD_EN   = 1'b1;
        LOAD_ADDR = 4'(a);
        LOAD_DATA = d;
        step();
        LOAD_EN   = 1'b0;
        mem_m[a]  = d;
    endtask

    task automatic push_expect();
        exp_t        e;
        logic [15:0] w;
        w    = mem_m[pc_m];
        e.op = w[15:12];
        e.p1 = w[11:6];
        e.p2 = w[5:0];
        e.pc = 4'(pc_m);
        sb.push_back(e);
    endtask

    task automatic wait_start();
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (START !== 1'b1 && n < 200);
        if (START !== 1'b1) chk("start_wait_expired", int'(START), 1);
    endtask

    // Plays one instruction: n_inc PCinc pulses, `pre` idle WAIT cycles, then
    // finish (optionally together with PCinc). drop tries a write while busy.
    task automatic issue(input int n_inc, input int both, input int pre, input bit drop);
        int incr;
        incr = (n_inc + both == 0) ? 1 : n_inc + both;
        push_expect();
        wait_start();
        step();
        if (drop) begin
            LOAD_EN   = 1'b1;
            LOAD_ADDR = 4'((pc_m + incr) % 16);
            LOAD_DATA = 16'hF000;
        end
        step();
        LOAD_EN = 1'b0;
        for (int i = 0; i < n_inc; i++) begin
            PCinc = 1'b1;
            step();
            PCinc = 1'b0;
            step();
        end
        repeat (pre) step();
        finish = 1'b1;
        PCinc  = 1'(both);
        step();
        finish = 1'b0;
        PCinc  = 1'b0;
        pc_m   = (pc_m + incr) % 16;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (DONE !== 1'b1 && n < 50);
        chk("done", int'(DONE), 1);
        chk("halt_pc", int'(PC), pc_m);
        chk("halt_busy", int'(BUSY), 0);
        chk("halt_sb_empty", sb.size(), 0);
    endtask

    task automatic random_instr();
        issue($urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 3), 1'b0);
    endtask

    initial begin
        logic [31:0] r;
        int          n;
        RESET = 1'b1; RUN = 1'b0; LOAD_EN = 1'b0; LOAD_ADDR = '0;
        LOAD_DATA = '0; PCinc = 1'b0; finish = 1'b0;
        #3 RESET = 1'b0;
        #1 reset_outputs_check();
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;
        step();

        // Directed program; the last load overlaps RUN, which must defer start.
        load(0, 16'h80D5);
        load(1, 16'h90D5);
        LOAD_EN = 1'b1; LOAD_ADDR = 4'd2; LOAD_DATA = 16'hF000; RUN = 1'b1;
        step();
        LOAD_EN  = 1'b0;
        mem_m[2] = 16'hF000;
        chk("load_and_run_stays_idle", int'(BUSY), 0);
        pc_m = 0;
        issue(1, 0, 0, 1'b0);
        issue(1, 0, 0, 1'b0);
        wait_done();
        step();
        chk("halted_holds_with_run", int'(DONE), 1);
        RUN = 1'b0;
        step(); step();
        chk("idle_after_run_low", int'(DONE), 0);

        // Random programs with a halt run at 13..15 that cannot be skipped.
        repeat (4) begin
            for (int i = 0; i < 13; i++) begin
                r = $urandom;
                load(i, {4'($urandom_range(0, 14)), r[11:0]});
            end
            for (int i = 13; i < 16; i++) begin
                r = $urandom;
                load(i, {HALT, r[11:0]});
            end
            pc_m = 0;
            RUN  = 1'b1;
            step();
            random_instr();
            RUN = 1'b0;
            while (mem_m[pc_m][15:12] != HALT) random_instr();
            wait_done();
            step();
        end

        // Full-memory program without halt: PC wraps and entry 0 reissues.
        for (int i = 0; i < 16; i++) begin
            r = $urandom;
            load(i, {4'($urandom_range(0, 14)), r[11:0]});
        end
        pc_m = 0;
        RUN  = 1'b1;
        step();
        issue(0, 0, 0, 1'b0);
        RUN = 1'b0;
        for (int k = 1; k < 16; k++) issue(0, 0, 0, 1'b0);
        chk("wrap_pc_model", pc_m, 0);
        issue(0, 0, 0, 1'b1);
        issue(0, 0, 0, 1'b0);

        // Reset in the middle of WAIT aborts the instruction.
        push_expect();
        wait_start();
        step(); step();
        RESET = 1'b0;
        #2 reset_outputs_check();
        chk("rst_sb_empty", sb.size(), 0);
        step(); step();
        RESET = 1'b1;
        pc_m  = 0;
        step();

        // Replay: finish on the last permitted WAIT cycle, then a timeout.
        RUN = 1'b1;
        step();
        issue(0, 0, TO - 2, 1'b0);
        RUN = 1'b0;
        push_expect();
        wait_start();
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (TIMEOUT !== 1'b1 && n < 200);
        chk("timeout_latency", n, TO + 1);
        chk("timeout_flag", int'(TIMEOUT), 1);
        chk("timeout_busy", int'(BUSY), 0);
        chk("timeout_done", int'(DONE), 0);
        RUN = 1'b1;
        repeat (5) step();
        chk("error_sticky", int'(TIMEOUT), 1);
        chk("error_no_restart", int'(BUSY), 0);
        RUN   = 1'b0;
        RESET = 1'b0;
        #2 chk("error_cleared_by_reset", int'(TIMEOUT), 0);
        step();
        RESET = 1'b1;
        step();
        chk("final_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_issuer.md
INSTR_ISSUER -- requirements
Module: instr_issuer

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 64: maximum WAIT cycles before ERROR.
REQ-002 The block SHALL have parameter HALT_OP, default 4'b1111: opcode that terminates a program.
REQ-003 Port CLK, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port RESET, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-005 Port RUN, input, 1 bit, SHALL be the program start request; level, sampled in IDLE and HALTED only.
REQ-006 Port LOAD_EN, input, 1 bit, SHALL be the instruction-memory write enable.
REQ-007 Port LOAD_ADDR, input, 4 bits, SHALL be the write address.
REQ-008 Port LOAD_DATA, input, 16 bits, SHALL be the write data: [15:12] opcode, [11:6] p1, [5:0] p2.
REQ-009 Port PCinc, input, 1 bit, SHALL be the PC-advance pulse from the control FSM.
REQ-010 Port finish, input, 1 bit, SHALL be the instruction-complete pulse from the control FSM.
REQ-011 Port START, output, 1 bit, SHALL be the one-cycle instruction-start pulse to the control FSM.
REQ-012 Ports OPCODE (4 bits), p1 (6 bits) and p2 (6 bits), outputs, SHALL carry the decoded instruction fields.
REQ-013 Port PC, output, 4 bits, SHALL be the current program counter.
REQ-014 Ports BUSY, DONE and TIMEOUT, outputs, 1 bit each, SHALL be the status flags.

Function
REQ-015 The block SHALL implement states IDLE, FETCH, ISSUE, WAIT, HALTED and ERROR.
REQ-016 In IDLE with RUN=1, the block SHALL clear PC to 0 and go to FETCH next cycle.
REQ-017 In FETCH, the block SHALL register mem[PC] into OPCODE/p1/p2, then go to HALTED if the opcode equals HALT_OP, else to ISSUE.
REQ-018 In ISSUE, the block SHALL assert START for exactly one cycle, clear the timeout counter and go to WAIT.
REQ-019 OPCODE/p1/p2 SHALL remain stable from ISSUE until the next FETCH.
REQ-020 In WAIT, each PCinc pulse SHALL increment PC by 1 modulo 16 (15 wraps to 0).
REQ-021 In WAIT, when finish=1, the block SHALL go to FETCH; if no PCinc was seen for the current instruction, the block SHALL increment PC once at that edge.
REQ-022 When PCinc and finish are asserted in the same cycle, the block SHALL increment PC exactly once.
REQ-023 In WAIT, the timeout counter SHALL increment each cycle; on reaching TIMEOUT_CYCLES without finish, the block SHALL go to ERROR.
REQ-024 In HALTED, DONE SHALL be 1; RUN=0 SHALL return the block to IDLE.
REQ-025 In ERROR, TIMEOUT SHALL be 1; the block SHALL leave ERROR only through reset.
REQ-026 BUSY SHALL be 1 in FETCH, ISSUE and WAIT, and 0 otherwise.
REQ-027 LOAD_EN SHALL write LOAD_DATA into mem[LOAD_ADDR] only when BUSY=0; writes while busy SHALL be dropped.
REQ-028 In IDLE with LOAD_EN=1 and RUN=1 in the same cycle, the block SHALL perform the write and defer the start until RUN=1 with LOAD_EN=0.
REQ-029 RUN deassertion during FETCH, ISSUE or WAIT SHALL be ignored; execution SHALL continue to HALTED or ERROR.
REQ-030 PCinc and finish SHALL be ignored outside WAIT.

Reset
REQ-031 While RESET=0, the block SHALL immediately force state=IDLE, START=0, OPCODE=0, p1=0, p2=0, PC=0, BUSY=0, DONE=0, TIMEOUT=0 and timeout counter=0.
REQ-032 Reset SHALL NOT clear the instruction memory contents.
REQ-033 Reset asserted mid-instruction SHALL abort that instruction with no further START pulse.

Structure
REQ-034 A shared package SHALL hold the state enum, the HALT_OP default and the opcode/p1/p2 field bit positions.
REQ-035 The 16x16 instruction storage SHALL be a sub-module instr_mem with one synchronous write port and one combinational read port.

Verification
REQ-036 Load mem0=0x80D5, mem1=0x90D5, mem2=0xF000, RUN=1, FSM model gives PCinc then finish -> START pulses twice with OPCODE/p1/p2 = 1000/000011/010101 then 1001/000011/010101; DONE=1 with PC=2.
REQ-037 FSM model never asserts finish, TIMEOUT_CYCLES=64 -> ERROR entered 64 cycles after the START pulse; TIMEOUT=1 and BUSY=0.
REQ-038 PCinc and finish asserted in the same cycle -> PC increments by exactly 1.
REQ-039 16 non-halt entries, no HALT_OP -> PC wraps from 15 to 0 and the instruction at entry 0 reissues.
REQ-040 RESET=0 pulsed during WAIT -> all outputs at reset values immediately; memory retained, so the next RUN replays the same program.
REQ-041 LOAD_EN=1 while BUSY=1 with LOAD_DATA=0xF000 at the address executed next -> write dropped and the original instruction executes.
